serial_ram: RTL and testbench

SERIAL_RAM -- requirements
Module: serial_ram

---
 rtl/serial_ram.sv | 161 ++++++++++++++++
 tb/tb_serial_ram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_ram.sv
// Nibble-serial RAM: a command nibble, RAM_ADDR_BITS/4 address nibbles, then four data nibbles in or out.
// Define SERIAL_RAM_WRITE_EN to enable write commands; without it the memory is read-only.
module serial_ram #(
  parameter int RAM_ADDR_BITS = 16,
  parameter int DELAY         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] addr_in,
  output logic [3:0] data_out
);

  localparam int         NA         = RAM_ADDR_BITS / 4;
  localparam int         DEPTH      = 1 << RAM_ADDR_BITS;
  localparam logic [7:0] NA_LAST    = 8'(NA - 1);
  localparam logic [7:0] DELAY_LAST = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
`ifdef SERIAL_RAM_WRITE_EN
    WDATA = 3'd4,
`endif
    RDATA = 3'd3
  } state_t;

  // With no read latency the address phase hands straight over to the data burst.
  localparam state_t AFTER_ADDR = (DELAY == 0) ? RDATA : WAIT;

  function automatic logic [3:0] nib_sel(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    nib_sel = word[3:0];
      2'd1:    nib_sel = word[7:4];
      2'd2:    nib_sel = word[11:8];
      2'd3:    nib_sel = word[15:12];
      default: nib_sel = 4'h0;
    endcase
  endfunction

  logic [15:0]              mem [DEPTH] = '{default: 16'h0000};
  state_t                   state_r, state_s;
  logic [7:0]               cnt_r, cnt_s;
  logic [RAM_ADDR_BITS-1:0] addr_r, addr_s;
  logic [3:0]               data_s;
`ifdef SERIAL_RAM_WRITE_EN
  logic                     wr_r, wr_s;
  logic [11:0]              wbuf_r, wbuf_s;
  logic                     mem_we_s;
`endif

  // Next-state, counter, address capture and read-nibble selection.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    addr_s   = addr_r;
    data_s   = 4'h0;
`ifdef SERIAL_RAM_WRITE_EN
    wr_s     = wr_r;
    wbuf_s   = wbuf_r;
    mem_we_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (addr_in[0]) begin
          state_s = ADDR;
          cnt_s   = 8'd0;
`ifdef SERIAL_RAM_WRITE_EN
          wr_s    = addr_in[1];
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        for (int i = 0; i < NA; i++) begin
          addr_s[i*4 +: 4] = (cnt_r == 8'(i)) ? addr_in : addr_r[i*4 +: 4];
        end
        if (cnt_r == NA_LAST) begin
          cnt_s = 8'd0;
`ifdef SERIAL_RAM_WRITE_EN
          state_s = wr_r ? WDATA : AFTER_ADDR;
`else
          state_s = AFTER_ADDR;
`endif
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      WAIT: begin
        if (cnt_r == DELAY_LAST) begin
          state_s = RDATA;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RDATA: begin
        data_s = nib_sel(mem[addr_r], cnt_r[1:0]);
        if (cnt_r == 8'd3) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
`ifdef SERIAL_RAM_WRITE_EN
      WDATA: begin
        for (int i = 0; i < 3; i++) begin
          wbuf_s[i*4 +: 4] = (cnt_r == 8'(i)) ? addr_in : wbuf_r[i*4 +: 4];
        end
        if (cnt_r == 8'd3) begin
          mem_we_s = 1'b1;
          state_s  = IDLE;
          cnt_s    = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Control and output registers; everything holds while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      addr_r   <= '0;
      data_out <= 4'h0;
`ifdef SERIAL_RAM_WRITE_EN
      wr_r     <= 1'b0;
      wbuf_r   <= 12'h000;
`endif
    end else if (enable) begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      addr_r   <= addr_s;
      data_out <= data_s;
`ifdef SERIAL_RAM_WRITE_EN
      wr_r     <= wr_s;
      wbuf_r   <= wbuf_s;
`endif
    end
  end

`ifdef SERIAL_RAM_WRITE_EN
  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (enable && mem_we_s) begin
      mem[addr_r] <= {addr_in, wbuf_r};
    end
  end
`endif

endmodule

// File: tb/tb_serial_ram.sv
// Directed bench for serial_ram: a DELAY=7/16-bit instance and a DELAY=0/4-bit instance.
// Honours SERIAL_RAM_WRITE_EN the same way as the design (writes vs. hierarchical preload).
module tb_serial_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] addr_in = 4'h0;
  logic [3:0] addr_in2 = 4'h0;
  logic [3:0] data_out;
  logic [3:0] data_out2;
  int         checks = 0;
  int         errors = 0;

  serial_ram #(.RAM_ADDR_BITS(16), .DELAY(7)) u_d7 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .addr_in(addr_in), .data_out(data_out)
  );

  serial_ram #(.RAM_ADDR_BITS(4), .DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .addr_in(addr_in2), .data_out(data_out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [3:0] v);
    if (sel) begin
      addr_in2 = v;
      addr_in  = 4'h0;
    end else begin
      addr_in  = v;
      addr_in2 = 4'h0;
    end
  endtask

  // One read transaction; g>0 drops enable for edges g..g+2, abort_k>=0 pulses reset after edge abort_k.
  task automatic rd_txn(input bit sel, input logic [3:0] cmd, input logic [15:0] a,
                        input logic [15:0] w, input logic [3:0] fill, input int g, input int abort_k);
    int na, dl, eff, last;
    logic [3:0] drv, expv;
    na   = sel ? 1 : 4;
    dl   = sel ? 0 : 7;
    last = na + dl + 5 + ((g > 0) ? 3 : 0);
    for (int k = 0; k <= last; k++) begin
      if (g > 0 && k >= g && k < g + 3) begin
        eff    = g - 1;
        enable = 1'b0;
        drv    = fill;
      end else begin
        eff    = (g > 0 && k >= g + 3) ? k - 3 : k;
        enable = 1'b1;
        if (eff == 0)                drv = cmd;
        else if (eff <= na)          drv = a[(eff-1)*4 +: 4];
        else if (eff <= na + dl + 4) drv = fill;
        else                         drv = 4'h0;
      end
      drive(sel, drv);
      @(posedge clk);
      #1;
      expv = (eff >= na + dl + 1 && eff <= na + dl + 4) ? w[(eff-na-dl-1)*4 +: 4] : 4'h0;
      check(sel ? "rd_d0" : "rd_d7", sel ? data_out2 : data_out, expv);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_async", sel ? data_out2 : data_out, 4'h0);
        rst_n = 1'b1;
        drive(sel, 4'h0);
        enable = 1'b1;
        return;
      end
    end
    enable = 1'b1;
  endtask

`ifdef SERIAL_RAM_WRITE_EN
  task automatic wr_txn(input bit sel, input logic [15:0] a, input logic [15:0] w, input int abort_k);
    int na;
    logic [3:0] drv;
    na = sel ? 1 : 4;
    for (int k = 0; k <= na + 4; k++) begin
      if (k == 0)       drv = 4'h3;
      else if (k <= na) drv = a[(k-1)*4 +: 4];
      else              drv = w[(k-na-1)*4 +: 4];
      drive(sel, drv);
      @(posedge clk);
      #1;
      check("wr_quiet", sel ? data_out2 : data_out, 4'h0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(sel, 4'h0);
        return;
      end
    end
    drive(sel, 4'h0);
  endtask
`endif

  task automatic load(input bit sel, input logic [15:0] a, input logic [15:0] w);
`ifdef SERIAL_RAM_WRITE_EN
    wr_txn(sel, a, w, -1);
`else
    if (sel) u_d0.mem[a[3:0]] = w;
    else     u_d7.mem[a] = w;
`endif
  endtask

  initial begin
    // Reset, with a would-be command on the bus that must be ignored.
    #2 rst_n = 1'b0;
    addr_in  = 4'h1;
    addr_in2 = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_d7", data_out, 4'h0);
    check("reset_d0", data_out2, 4'h0);
    addr_in  = 4'h0;
    addr_in2 = 4'h0;
    rst_n    = 1'b1;

    // Fresh memory reads zero; then the BEEF word at 1234 (nibbles F,E,E,B on t0+12..15).
    rd_txn(1'b0, 4'h1, 16'h0000, 16'h0000, 4'h0, 0, -1);
    load(1'b0, 16'h1234, 16'hBEEF);
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 0, -1);
    // Busy bus during WAIT/RDATA must be ignored.
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'hF, 0, -1);

    // Zero-latency, single-address-nibble instance: first nibble at t0+2.
    load(1'b1, 16'h000A, 16'h5A3C);
    rd_txn(1'b1, 4'h1, 16'h000A, 16'h5A3C, 4'hF, 0, -1);
    rd_txn(1'b1, 4'h1, 16'h0003, 16'h0000, 4'h0, 0, -1);

    // Enable dropped for 3 cycles in WAIT, then in RDATA.
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 7, -1);
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 13, -1);

    // addr_in held at 1: back-to-back reads of 1111 every 16 edges.
    load(1'b0, 16'h1111, 16'hC0DE);
    addr_in = 4'h1;
    for (int k = 0; k < 32; k++) begin
      logic [15:0] w;
      w = 16'hC0DE;
      @(posedge clk);
      #1;
      check("b2b", data_out, ((k % 16) >= 12) ? w[((k % 16) - 12)*4 +: 4] : 4'h0);
    end
    addr_in = 4'h0;
    @(posedge clk);
    #1;
    check("b2b_end", data_out, 4'h0);

    // Top address and address zero are independent.
    load(1'b0, 16'hFFFF, 16'h7E81);
    rd_txn(1'b0, 4'h1, 16'hFFFF, 16'h7E81, 4'h0, 0, -1);
    rd_txn(1'b0, 4'h1, 16'h0000, 16'h0000, 4'h0, 0, -1);

`ifdef SERIAL_RAM_WRITE_EN
    // Write aborted by reset after the first data nibble leaves memory intact.
    wr_txn(1'b0, 16'h1234, 16'h0000, 5);
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 0, -1);
`else
    // Write-looking command behaves as a read and changes nothing.
    rd_txn(1'b0, 4'h3, 16'h1234, 16'hBEEF, 4'h3, 0, -1);
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 0, -1);
`endif

    // Reset during RDATA (after nibble 1): output clears at once, data retained.
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 0, 13);
    rd_txn(1'b0, 4'h1, 16'h1234, 16'hBEEF, 4'h0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
